// File: rtl/ffinv_pkg.sv
// Shared constants and state encoding for the GF(2^8) inverse block.
package ffinv_pkg;

    localparam logic [7:0] POLY_DEFAULT = 8'h1B;
    localparam logic [2:0] LAST_STEP    = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gf_mul8.sv
// Combinational GF(2^8) multiplier, reduced modulo {1,POLY}.
module gf_mul8
    import ffinv_pkg::*;
#(
    parameter logic [7:0] POLY = POLY_DEFAULT
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] prod;
    logic [7:0] shifted;

    // Shift-and-xor: shifted holds a * x^i, folded back whenever bit 7 falls off.
    always_comb begin
        prod    = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ shifted;
            end
            shifted = {shifted[6:0], 1'b0} ^ (shifted[7] ? POLY : 8'h00);
        end
    end

    assign p = prod;

endmodule

// File: rtl/ffinv_seq.sv
// Sequential GF(2^8) inverter: computes a^254 by six square-and-multiply steps and a final square.
module ffinv_seq
    import ffinv_pkg::*;
#(
    parameter logic [7:0] POLY = POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    state_t     state;
    logic [7:0] op_a;
    logic [7:0] acc;
    logic [2:0] cnt;
    logic [7:0] sq;
    logic [7:0] sq_mul;
    logic       unused_in_bits;

    assign unused_in_bits = ^in_data[31:8];

    gf_mul8 #(
        .POLY (POLY)
    ) u_square (
        .a (acc),
        .b (acc),
        .p (sq)
    );

    gf_mul8 #(
        .POLY (POLY)
    ) u_mult (
        .a (sq),
        .b (op_a),
        .p (sq_mul)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= 8'h00;
            acc   <= 8'h00;
            cnt   <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_data[7:0];
                        acc   <= in_data[7:0];
                        cnt   <= 3'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Exponent goes 1 -> 3 -> 7 ... -> 127, then the last square lands on 254.
                    acc <= (cnt == LAST_STEP) ? sq : sq_mul;
                    cnt <= cnt + 3'd1;
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign out_data  = out_valid ? {24'h000000, acc} : 32'h00000000;

endmodule

// File: tb/tb_ffinv_seq.sv
// Directed bench for ffinv_seq: known vectors, backpressure, mid-calculation reset, all 256 operands.
module tb_ffinv_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int total;
    int failed;

    ffinv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] full;
        full = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) full = full ^ (16'(x) << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (full[i]) full = full ^ (16'h011B << (i - 8));
        end
        return full[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand from IDLE and wait (bounded) for out_valid; out_ready is left as-is.
    task automatic offer(input logic [31:0] d, output logic [31:0] res, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        res = out_data;
    endtask

    // Full transfer with out_ready high: checks latency, result, and the return to IDLE.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        out_ready = 1'b1;
        offer(d, res, lat);
        chk({tag, "_latency"}, 32'(lat), 32'd7);
        chk({tag, "_data"}, res, exp);
        step();
        chk({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          seen_valid;

        total     = 0;
        failed    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        step();
        step();
        chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        run_op("vec_53", 32'h0000_0053, 32'h0000_00CA);
        run_op("vec_02", 32'h0000_0002, 32'h0000_008D);
        run_op("vec_01", 32'h0000_0001, 32'h0000_0001);
        run_op("vec_00", 32'h0000_0000, 32'h0000_0000);
        run_op("vec_upper", 32'hFFFF_FF53, 32'h0000_00CA);

        // Backpressure: hold result for 20 cycles while a stray operand is offered.
        out_ready = 1'b0;
        offer(32'h0000_0053, res, lat);
        chk("bp_latency", 32'(lat), 32'd7);
        chk("bp_data", res, 32'h0000_00CA);
        in_valid = 1'b1;
        in_data  = 32'h0000_0002;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold_data", out_data, 32'h0000_00CA);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_release_valid", {31'b0, out_valid}, 32'd0);

        // Reset on the 4th CALC cycle discards the operation.
        in_valid = 1'b1;
        in_data  = 32'h0000_0053;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("rst_mid_not_done", {31'b0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_idle", {31'b0, in_ready}, 32'd1);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen_valid++;
        end
        chk("rst_mid_no_valid", 32'(seen_valid), 32'd0);
        run_op("rst_next_op", 32'h0000_0002, 32'h0000_008D);

        // All operands: result times operand must be 1, and zero maps to zero.
        out_ready = 1'b1;
        for (int a = 0; a < 256; a++) begin
            offer(32'(a), res, lat);
            chk("exh_latency", 32'(lat), 32'd7);
            chk("exh_upper", {8'h0, res[31:8]}, 32'h0);
            if (a == 0) chk("exh_zero", res, 32'h0);
            else chk("exh_inverse", {24'h0, model_mul(8'(a), res[7:0])}, 32'h1);
            step();
        end

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule

// File: doc/ffinv_seq.md
FFINV_SEQ -- requirements
Module: ffinv_seq

Interface
REQ-001 Parameter POLY, default 8'h1B, low 8 bits of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the operand on in_data is valid.
REQ-005 in_ready  output  1  the block can accept an operand.
REQ-006 in_data  input  32  operand; only bits [7:0] are used, bits [31:8] are ignored.
REQ-007 out_valid  output  1  the result on out_data is valid.
REQ-008 out_ready  input  1  the consumer accepts the result.
REQ-009 out_data  output  32  multiplicative inverse in GF(2^8), zero-extended; bits [31:8] are always 0.

Function
REQ-010 The block computes out = a^254 mod POLY, where a = in_data[7:0]; this gives a^-1 for a != 0 and 0 for a = 0.
REQ-011 The state machine has three states: IDLE, CALC and DONE.
REQ-012 In IDLE, in_ready = 1 and out_valid = 0.
REQ-013 In IDLE, a rising edge with in_valid = 1 captures the operand into register A and into accumulator R, clears step counter CNT (3 bits), and moves to CALC.
REQ-014 In CALC, in_ready = 0 and out_valid = 0.
REQ-015 In CALC, each edge updates the accumulator and counter: for CNT = 0..5, R <= (R*R)*A, giving A^3 ... A^127 in turn; for CNT = 6, R <= R*R, giving A^254.
REQ-016 In CALC, CNT increments every cycle, and the edge that completes step CNT = 6 moves the block to DONE.
REQ-017 Latency: out_valid rises exactly 7 clock edges after the accepting edge, with no data-dependent variation.
REQ-018 In DONE, out_valid = 1, out_data = {24'b0, R}, and in_ready = 0.
REQ-019 In DONE, out_data holds stable while out_ready = 0, for an unbounded number of cycles.
REQ-020 In DONE, an edge with out_ready = 1 completes the transfer and moves the block to IDLE; a new operand is accepted no earlier than the following edge.
REQ-021 Sustained throughput is one result per 9 cycles when out_ready is held at 1.
REQ-022 in_valid asserted while in CALC or DONE is ignored; no operand is captured.
REQ-023 All GF multiplications are polynomial products reduced modulo {1,POLY}; no integer carries are used.

Reset
REQ-024 When rst = 1 on an edge, the block enters IDLE and clears A, R and CNT to 0, taking priority over every other event.
REQ-025 A reset during CALC or DONE discards the operation in progress; no out_valid pulse follows.
REQ-026 Output values while rst is asserted are in_ready = 0 (forced low by rst), out_valid = 0 and out_data = 0.

Structure
REQ-027 A shared package ffinv_pkg holds the POLY default, the state enum (IDLE/CALC/DONE) and the step constant LAST_STEP = 6.
REQ-028 The block has one combinational sub-module, gf_mul8 (8x8 multiplier with parameter POLY), instantiated twice in series for square-then-multiply.
REQ-029 There is no memory or lookup table inside the block.

Verification
REQ-030 Known-vector scenario: drive in_data 0x00000053 with out_ready = 1 -> out_data 0x000000CA, with out_valid rising exactly 7 edges after the accepting edge.
REQ-031 Boundary-operand scenario: in_data 0x00000002 -> 0x0000008D; 0x00000001 -> 0x00000001; 0x00000000 -> 0x00000000; 0xFFFFFF53 -> 0x000000CA (upper input bits ignored).
REQ-032 Backpressure scenario: hold out_ready = 0 for 20 cycles in DONE -> out_data stays stable, in_ready = 0, and a second in_valid is not accepted; releasing out_ready gives IDLE on the next edge.
REQ-033 Reset scenario: assert rst on the 4th CALC cycle -> IDLE on the next edge, no out_valid, and the next operand is computed correctly.
REQ-034 Exhaustive scenario: all 256 operands, checked against a bench model -> for every a != 0, gf_mul(a, out) = 0x01, and out_data[31:8] = 0 throughout.
